// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, funct fields, control typedefs and the
// instruction-to-control and immediate-extension helpers used by decode_stage.
package decode_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_src_e;

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    result_src_e resultSrc;
    alu_ctrl_e   aluControl;
    logic        aluSrc;
    imm_src_e    immSrc;
    logic        branch;
    logic        branchNe;
    logic        jump;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immExt;
    logic [31:0] pcPlus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memWrite;
    result_src_e resultSrc;
    alu_ctrl_e   aluControl;
    logic        aluSrc;
  } ex_reg_t;

  localparam ctrl_t CTRL_NOP = '{
    regWrite:   1'b0,
    memWrite:   1'b0,
    resultSrc:  RES_ALU,
    aluControl: ALU_ADD,
    aluSrc:     1'b0,
    immSrc:     IMM_NONE,
    branch:     1'b0,
    branchNe:   1'b0,
    jump:       1'b0
  };

  // Unsupported opcodes and funct combinations fall through as CTRL_NOP.
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t      c;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = instr[6:0];
    f3 = instr[14:12];
    f7 = instr[31:25];
    c  = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.regWrite = 1'b1;
        case ({f7, f3})
          {F7_BASE, F3_ADD_SUB}: c.aluControl = ALU_ADD;
          {F7_ALT,  F3_ADD_SUB}: c.aluControl = ALU_SUB;
          {F7_BASE, F3_AND}:     c.aluControl = ALU_AND;
          {F7_BASE, F3_OR}:      c.aluControl = ALU_OR;
          {F7_BASE, F3_SLT}:     c.aluControl = ALU_SLT;
          default:               c.regWrite   = 1'b0;
        endcase
      end
      OP_ADDI: if (f3 == F3_ADDI) begin
        c.regWrite = 1'b1;
        c.aluSrc   = 1'b1;
        c.immSrc   = IMM_I;
      end
      OP_LOAD: if (f3 == F3_LW) begin
        c.regWrite  = 1'b1;
        c.aluSrc    = 1'b1;
        c.resultSrc = RES_MEM;
        c.immSrc    = IMM_I;
      end
      OP_STORE: if (f3 == F3_SW) begin
        c.memWrite = 1'b1;
        c.aluSrc   = 1'b1;
        c.immSrc   = IMM_S;
      end
      OP_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE) begin
        c.branch     = 1'b1;
        c.branchNe   = (f3 == F3_BNE);
        c.aluControl = ALU_SUB;
        c.immSrc     = IMM_B;
      end
      OP_JAL: begin
        c.regWrite  = 1'b1;
        c.resultSrc = RES_PC4;
        c.immSrc    = IMM_J;
        c.jump      = 1'b1;
      end
      OP_LUI: begin
        c.regWrite = 1'b1;
        c.aluSrc   = 1'b1;
        c.immSrc   = IMM_U;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] extend_imm(input logic [31:0] instr, input imm_src_e src);
    case (src)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file, two read ports and one write port; x0 is hardwired to
// zero and a same-cycle write is bypassed onto matching reads.
module regfile
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // The x0 check comes first so a write aimed at x0 is never bypassed.
  assign rdata1_o = (raddr1_i == 5'd0)                  ? 32'd0   :
                    (we_i && (waddr_i == raddr1_i))     ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0)                  ? 32'd0   :
                    (we_i && (waddr_i == raddr2_i))     ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, control decode, early branch/jump resolution and
// the D->E pipeline register. DECODE_BRANCH_FWD_EN adds M-stage comparator forwarding.
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
`ifdef DECODE_BRANCH_FWD_EN
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [31:0] ALUOutM,
`endif
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcE
);

  ctrl_t       ctrlD;
  logic [31:0] rd1D;
  logic [31:0] rd2D;
  logic [31:0] immExtD;
  logic [31:0] cmpAD;
  logic [31:0] cmpBD;
  ex_reg_t     exReg_d;
  ex_reg_t     exReg_q;

  assign Rs1D    = InstrD[19:15];
  assign Rs2D    = InstrD[24:20];
  assign ctrlD   = decode_ctrl(InstrD);
  assign immExtD = extend_imm(InstrD, ctrlD.immSrc);

  regfile u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (RegWriteW),
    .waddr_i  (RdW),
    .wdata_i  (ResultW),
    .raddr1_i (Rs1D),
    .raddr2_i (Rs2D),
    .rdata1_o (rd1D),
    .rdata2_o (rd2D)
  );

`ifdef DECODE_BRANCH_FWD_EN
  assign cmpAD = ForwardAD ? ALUOutM : rd1D;
  assign cmpBD = ForwardBD ? ALUOutM : rd2D;
`else
  assign cmpAD = rd1D;
  assign cmpBD = rd2D;
`endif

  // bne inverts the equality result; jal redirects unconditionally.
  assign PCSrcD    = ctrlD.jump | (ctrlD.branch & ((cmpAD == cmpBD) ^ ctrlD.branchNe));
  assign PCBranchD = PCPlus4D - 32'd4 + immExtD;

  always_comb begin
    exReg_d = '0;
    if (!FlushE) begin
      exReg_d.rd1        = rd1D;
      exReg_d.rd2        = rd2D;
      exReg_d.immExt     = immExtD;
      exReg_d.pcPlus4    = PCPlus4D;
      exReg_d.rs1        = Rs1D;
      exReg_d.rs2        = Rs2D;
      exReg_d.rd         = InstrD[11:7];
      exReg_d.regWrite   = ctrlD.regWrite;
      exReg_d.memWrite   = ctrlD.memWrite;
      exReg_d.resultSrc  = ctrlD.resultSrc;
      exReg_d.aluControl = ctrlD.aluControl;
      exReg_d.aluSrc     = ctrlD.aluSrc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exReg_q <= '0;
    else        exReg_q <= exReg_d;
  end

  assign RD1E        = exReg_q.rd1;
  assign RD2E        = exReg_q.rd2;
  assign ImmExtE     = exReg_q.immExt;
  assign PCPlus4E    = exReg_q.pcPlus4;
  assign Rs1E        = exReg_q.rs1;
  assign Rs2E        = exReg_q.rs2;
  assign RdE         = exReg_q.rd;
  assign RegWriteE   = exReg_q.regWrite;
  assign MemWriteE   = exReg_q.memWrite;
  assign ResultSrcE  = exReg_q.resultSrc;
  assign ALUControlE = exReg_q.aluControl;
  assign ALUSrcE     = exReg_q.aluSrc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (default build, DECODE_BRANCH_FWD_EN undefined):
// directed scenarios followed by randomized instructions against an encoding-level model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        FlushE;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic [4:0]  Rs1D, Rs2D;
  logic [31:0] RD1E, RD2E, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  int total = 0;
  int bad   = 0;

  logic [31:0]  refRegs [32];
  logic [150:0] eAll;
  logic [7:0]   eCtrl;

  localparam logic [3:0] K_NOP = 4'd0, K_R = 4'd1, K_ADDI = 4'd2, K_LW = 4'd3, K_SW = 4'd4,
                         K_BEQ = 4'd5, K_BNE = 4'd6, K_JAL = 4'd7, K_LUI = 4'd8;

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  kind;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  alu;
  } txn_t;

  always #5 clk = ~clk;

  assign eAll  = {RD1E, RD2E, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE,
                  RegWriteE, MemWriteE, ResultSrcE, ALUControlE, ALUSrcE};
  assign eCtrl = {RegWriteE, MemWriteE, ResultSrcE, ALUControlE, ALUSrcE};

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE)
  );

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encI(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encS(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input int off, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
    logic [31:0] v;
    v = off;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encJ(input int off, input logic [4:0] rd);
    logic [31:0] v;
    v = off;
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
  endfunction

  // Builds a random instruction of a random kind, remembering the intended immediate value.
  function automatic txn_t makeTxn(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    txn_t        t;
    logic [31:0] pv, rnd, iv;
    int          imm;
    pv  = $urandom_range(0, 8);
    rnd = $urandom;
    t   = '0;
    t.kind = pv[3:0];
    t.rd   = rd;
    imm    = int'($urandom_range(0, 4095)) - 2048;
    case (t.kind)
      K_NOP: begin
        case (rnd[1:0])
          2'd0:    t.instr = {rnd[31:7], 7'h7F};
          2'd1:    t.instr = {rnd[31:7], 7'h17};
          2'd2:    t.instr = {rnd[31:7], 7'h67};
          default: t.instr = {rnd[31:7], 7'h73};
        endcase
      end
      K_R: begin
        case (rnd % 5)
          0:       begin t.instr = encR(7'h00, rs2, rs1, 3'b000, rd); t.alu = 3'b000; end
          1:       begin t.instr = encR(7'h20, rs2, rs1, 3'b000, rd); t.alu = 3'b001; end
          2:       begin t.instr = encR(7'h00, rs2, rs1, 3'b111, rd); t.alu = 3'b010; end
          3:       begin t.instr = encR(7'h00, rs2, rs1, 3'b110, rd); t.alu = 3'b011; end
          default: begin t.instr = encR(7'h00, rs2, rs1, 3'b010, rd); t.alu = 3'b101; end
        endcase
      end
      K_ADDI: t.instr = encI(imm, rs1, 3'b000, rd, 7'h13);
      K_LW:   t.instr = encI(imm, rs1, 3'b010, rd, 7'h03);
      K_SW:   t.instr = encS(imm, rs2, rs1);
      K_BEQ, K_BNE: begin
        imm     = 2 * imm;
        t.instr = encB(imm, rs2, rs1, (t.kind == K_BNE) ? 3'b001 : 3'b000);
      end
      K_JAL: begin
        imm     = 2 * (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19));
        t.instr = encJ(imm, rd);
      end
      default: begin
        t.instr = {rnd[31:12], rd, 7'b0110111};
        imm     = int'(rnd[31:12]) * 4096;
      end
    endcase
    iv    = imm;
    t.imm = iv;
    return t;
  endfunction

  // Expected {RegWrite, MemWrite, ResultSrc, ALUControl, ALUSrc} for each instruction kind.
  function automatic logic [7:0] expCtrl(input txn_t t);
    case (t.kind)
      K_R:          return {1'b1, 1'b0, 2'b00, t.alu, 1'b0};
      K_ADDI:       return {1'b1, 1'b0, 2'b00, 3'b000, 1'b1};
      K_LW:         return {1'b1, 1'b0, 2'b01, 3'b000, 1'b1};
      K_SW:         return {1'b0, 1'b1, 2'b00, 3'b000, 1'b1};
      K_BEQ, K_BNE: return {1'b0, 1'b0, 2'b00, 3'b001, 1'b0};
      K_JAL:        return {1'b1, 1'b0, 2'b10, 3'b000, 1'b0};
      K_LUI:        return {1'b1, 1'b0, 2'b00, 3'b000, 1'b1};
      default:      return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] refRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && RdW == a) return ResultW;
    return refRegs[a];
  endfunction

  task automatic idleInputs();
    RegWriteW = 1'b0;
    RdW       = 5'd0;
    ResultW   = 32'd0;
    FlushE    = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    idleInputs();
    InstrD   = encI(5, 5'd0, 3'b000, 5'd1, 7'h13);
    PCPlus4D = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    total++; if (eAll !== '0) begin bad++; $display("[TB] FAIL reset_clear: got %h expected 0", eAll); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    total++; if (ImmExtE !== 32'd5) begin bad++; $display("[TB] FAIL reset_imm: got %h expected 5", ImmExtE); end
    total++; if (RegWriteE !== 1'b1) begin bad++; $display("[TB] FAIL reset_regwrite: got %b expected 1", RegWriteE); end
    total++; if (RdE !== 5'd1) begin bad++; $display("[TB] FAIL reset_rd: got %0d expected 1", RdE); end
    total++; if (ALUControlE !== 3'b000) begin bad++; $display("[TB] FAIL reset_alu: got %b expected 000", ALUControlE); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    InstrD = encR(7'h00, 5'd0, 5'd3, 3'b000, 5'd5);
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF;
    @(posedge clk); #1;
    total++; if (RD1E !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL bypass_rd1: got %h expected deadbeef", RD1E); end
    @(negedge clk);
    idleInputs();
    InstrD = encR(7'h00, 5'd3, 5'd0, 3'b000, 5'd5);
    @(posedge clk); #1;
    total++; if (RD2E !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL stored_rd2: got %h expected deadbeef", RD2E); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    InstrD = encR(7'h00, 5'd0, 5'd0, 3'b000, 5'd5);
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'd7;
    @(posedge clk); #1;
    total++; if (RD1E !== 32'd0) begin bad++; $display("[TB] FAIL x0_bypass: got %h expected 0", RD1E); end
    @(negedge clk) idleInputs();
    @(posedge clk); #1;
    total++; if (RD1E !== 32'd0) begin bad++; $display("[TB] FAIL x0_read: got %h expected 0", RD1E); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    InstrD = 32'h00000013;
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'd9;
    @(negedge clk) RdW = 5'd2;
    @(negedge clk);
    idleInputs();
    PCPlus4D = 32'h104;
    InstrD = encB(-8, 5'd2, 5'd1, 3'b000);
    #1;
    total++; if (PCSrcD !== 1'b1) begin bad++; $display("[TB] FAIL beq_taken: got %b expected 1", PCSrcD); end
    total++; if (PCBranchD !== 32'hF8) begin bad++; $display("[TB] FAIL beq_target: got %h expected f8", PCBranchD); end
    InstrD = encB(-8, 5'd2, 5'd1, 3'b001);
    #1;
    total++; if (PCSrcD !== 1'b0) begin bad++; $display("[TB] FAIL bne_equal: got %b expected 0", PCSrcD); end
    RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'd10;
    #1;
    total++; if (PCSrcD !== 1'b1) begin bad++; $display("[TB] FAIL bne_bypass: got %b expected 1", PCSrcD); end
    InstrD = encB(-8, 5'd2, 5'd1, 3'b000);
    #1;
    total++; if (PCSrcD !== 1'b0) begin bad++; $display("[TB] FAIL beq_bypass: got %b expected 0", PCSrcD); end
  endtask

  task automatic test_jal();
    @(negedge clk);
    idleInputs();
    PCPlus4D = 32'h4;
    InstrD = encJ(-8, 5'd1);
    #1;
    total++; if (PCSrcD !== 1'b1) begin bad++; $display("[TB] FAIL jal_taken: got %b expected 1", PCSrcD); end
    total++; if (PCBranchD !== 32'hFFFFFFF8) begin bad++; $display("[TB] FAIL jal_wrap: got %h expected fffffff8", PCBranchD); end
    @(posedge clk); #1;
    total++; if (ResultSrcE !== 2'b10) begin bad++; $display("[TB] FAIL jal_resultsrc: got %b expected 10", ResultSrcE); end
    total++; if (ImmExtE !== 32'hFFFFFFF8) begin bad++; $display("[TB] FAIL jal_imm: got %h expected fffffff8", ImmExtE); end
  endtask

  task automatic test_flush_nop();
    @(negedge clk);
    FlushE = 1'b1;
    InstrD = encS(4, 5'd2, 5'd1);
    RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'hCAFEF00D;
    @(posedge clk); #1;
    total++; if (MemWriteE !== 1'b0 || RegWriteE !== 1'b0) begin bad++; $display("[TB] FAIL flush_ctrl: got mw=%b rw=%b expected 0 0", MemWriteE, RegWriteE); end
    total++; if (eAll !== '0) begin bad++; $display("[TB] FAIL flush_all: got %h expected 0", eAll); end
    @(negedge clk);
    idleInputs();
    InstrD = encS(4, 5'd4, 5'd1);
    @(posedge clk); #1;
    total++; if (MemWriteE !== 1'b1) begin bad++; $display("[TB] FAIL sw_memwrite: got %b expected 1", MemWriteE); end
    total++; if (RD2E !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL flush_writeback: got %h expected cafef00d", RD2E); end
    @(negedge clk) InstrD = 32'hFFFFFFFF;
    #1;
    total++; if (PCSrcD !== 1'b0) begin bad++; $display("[TB] FAIL nop_pcsrc: got %b expected 0", PCSrcD); end
    @(posedge clk); #1;
    total++; if (eCtrl !== 8'h00) begin bad++; $display("[TB] FAIL nop_ctrl: got %h expected 00", eCtrl); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    InstrD = encR(7'h00, 5'd0, 5'd0, 3'b000, 5'd1);
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h12345678;
    @(negedge clk);
    RdW = 5'd6; ResultW = 32'h55;
    InstrD = encI(1, 5'd5, 3'b000, 5'd2, 7'h13);
    #2 reset = 1'b0;
    #1;
    total++; if (eAll !== '0) begin bad++; $display("[TB] FAIL async_reset: got %h expected 0", eAll); end
    @(negedge clk);
    reset = 1'b1;
    idleInputs();
    InstrD = encR(7'h00, 5'd6, 5'd5, 3'b000, 5'd1);
    @(posedge clk); #1;
    total++; if (RD1E !== 32'd0) begin bad++; $display("[TB] FAIL reset_regs_x5: got %h expected 0", RD1E); end
    total++; if (RD2E !== 32'd0) begin bad++; $display("[TB] FAIL reset_nowrite_x6: got %h expected 0", RD2E); end
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
  endtask

  task automatic test_random();
    txn_t        t;
    logic [31:0] rnd, pc4, expRd1, expRd2;
    logic [4:0]  rs1, rs2;
    logic        expSrc, hasRd, hasImm;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rnd = $urandom;
      rs1 = rnd[4:0];
      rs2 = (rnd[26:25] == 2'b00) ? rs1 : rnd[9:5];
      t   = makeTxn(rs1, rs2, rnd[14:10]);
      pc4 = $urandom;
      pc4[1:0] = 2'b00;
      InstrD    = t.instr;
      PCPlus4D  = pc4;
      RegWriteW = rnd[15];
      RdW       = rnd[20:16];
      ResultW   = $urandom;
      FlushE    = (rnd[23:21] == 3'b000);
      #1;
      expRd1 = refRead(t.instr[19:15]);
      expRd2 = refRead(t.instr[24:20]);
      expSrc = (t.kind == K_JAL) || (t.kind == K_BEQ && expRd1 == expRd2) ||
               (t.kind == K_BNE && expRd1 != expRd2);
      hasRd  = (t.kind == K_R) || (t.kind == K_ADDI) || (t.kind == K_LW) ||
               (t.kind == K_JAL) || (t.kind == K_LUI);
      hasImm = (t.kind != K_NOP) && (t.kind != K_R);
      total++; if (PCSrcD !== expSrc) begin bad++; $display("[TB] FAIL rnd_pcsrc: instr %h got %b expected %b", t.instr, PCSrcD, expSrc); end
      if (t.kind == K_BEQ || t.kind == K_BNE || t.kind == K_JAL) begin
        total++; if (PCBranchD !== pc4 - 32'd4 + t.imm) begin bad++; $display("[TB] FAIL rnd_target: instr %h got %h expected %h", t.instr, PCBranchD, pc4 - 32'd4 + t.imm); end
      end
      @(posedge clk); #1;
      if (FlushE) begin
        total++; if (eAll !== '0) begin bad++; $display("[TB] FAIL rnd_flush: got %h expected 0", eAll); end
      end else begin
        total++; if (eCtrl !== expCtrl(t)) begin bad++; $display("[TB] FAIL rnd_ctrl: instr %h got %h expected %h", t.instr, eCtrl, expCtrl(t)); end
        total++; if (RD1E !== expRd1 || RD2E !== expRd2) begin bad++; $display("[TB] FAIL rnd_operands: got %h %h expected %h %h", RD1E, RD2E, expRd1, expRd2); end
        total++; if (PCPlus4E !== pc4 || Rs1E !== t.instr[19:15] || Rs2E !== t.instr[24:20]) begin bad++; $display("[TB] FAIL rnd_fields: got %h %0d %0d expected %h %0d %0d", PCPlus4E, Rs1E, Rs2E, pc4, t.instr[19:15], t.instr[24:20]); end
        if (hasRd) begin
          total++; if (RdE !== t.rd) begin bad++; $display("[TB] FAIL rnd_rd: got %0d expected %0d", RdE, t.rd); end
        end
        if (hasImm) begin
          total++; if (ImmExtE !== t.imm) begin bad++; $display("[TB] FAIL rnd_imm: instr %h got %h expected %h", t.instr, ImmExtE, t.imm); end
        end
      end
      if (RegWriteW && RdW != 5'd0) refRegs[RdW] = ResultW;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
    test_reset();
    test_bypass();
    test_x0();
    test_branch();
    test_jal();
    test_flush_nop();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: clk in 1, clock, all state on rising edge.
REQ-002 SHALL have: reset in 1, asynchronous active-low reset.
REQ-003 SHALL have: InstrD in 32, instruction from the fetch pipeline register.
REQ-004 SHALL have: PCPlus4D in 32, PC+4 of InstrD.
REQ-005 SHALL have: RegWriteW in 1, RdW in 5, ResultW in 32, the writeback port.
REQ-006 SHALL have: FlushE in 1, which clears the D->E register to a bubble.
REQ-007 SHALL have: PCSrcD out 1, which redirects fetch this cycle.
REQ-008 SHALL have: PCBranchD out 32, the redirect target.
REQ-009 SHALL have: Rs1D out 5 and Rs2D out 5, for the hazard unit.
REQ-010 SHALL have these registered execute outputs: RD1E 32, RD2E 32, ImmExtE 32, PCPlus4E 32, Rs1E 5, Rs2E 5, RdE 5, RegWriteE 1, MemWriteE 1, ResultSrcE 2, ALUControlE 3, ALUSrcE 1.

Function
REQ-011 SHALL contain a 32x32 register file with x0 reading 0 and ignoring writes.
REQ-012 SHALL write the register file on the rising clk edge when RegWriteW=1 and RdW!=0.
REQ-013 SHALL bypass reads: if RegWriteW=1, RdW!=0 and RdW equals a read address, that read returns ResultW in the same cycle.
REQ-014 SHALL decode the following opcodes; any other opcode yields all-zero control (NOP), PCSrcD=0.
- R-type: add, sub, and, or, slt
- addi
- lw, sw
- beq, bne
- jal
- lui
REQ-015 SHALL encode ALUControl as: add=000, sub=001, and=010, or=011, slt=101. ResultSrc SHALL be ALU=00, mem=01, PC+4=10.
REQ-016 SHALL sign-extend immediates per I/S/B/J format.
REQ-017 SHALL produce the U immediate as {imm[31:12],12'b0}.
REQ-018 SHALL compute PCBranchD = (PCPlus4D - 4) + ImmExt, modulo 2^32 (wraps, no overflow flag).
REQ-019 SHALL assert PCSrcD combinationally in the same cycle as InstrD under these conditions:
- jal
- beq with equal operands
- bne with unequal operands
REQ-020 SHALL register all execute outputs one cycle after decode (latency 1).
REQ-021 SHALL, when FlushE=1 at a clock edge, load RegWriteE=0, MemWriteE=0, RdE=0 and all other E outputs=0. FlushE SHALL take priority over the new decode.
REQ-022 SHALL keep writeback (REQ-012) independent of FlushE when FlushE and RegWriteW occur in the same cycle.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear all E outputs and all 32 registers to 0.
REQ-024 SHALL, on reset asserted mid-operation, discard any in-flight decode; no write SHALL occur during reset.

Configuration
REQ-025 SHALL, with DECODE_BRANCH_FWD_EN defined, add these ports:
- ForwardAD in 1, ForwardBD in 1
- ALUOutM in 32
When forwarding is selected, the branch comparator operand SHALL be ALUOutM.
REQ-026 SHALL, without DECODE_BRANCH_FWD_EN, omit those ports; the comparator SHALL use register-file reads (with REQ-013 bypass) only.

Structure
REQ-027 SHALL place the following in shared package decode_pkg:
- opcode constants
- funct3/funct7 constants
- ALUControl, ResultSrc and ImmSrc typedefs
REQ-028 SHALL implement the register file as sub-module regfile (2 read ports, 1 write port, bypass included).

Verification
REQ-029 SHALL cover: reset low with InstrD=addi x1,x0,5 -> all E outputs 0; after release and one edge, ImmExtE=5, RegWriteE=1, RdE=1, ALUControlE=000.
REQ-030 SHALL cover: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, with InstrD reading rs1=x3 the same cycle -> next edge RD1E=0xDEADBEEF.
REQ-031 SHALL cover: RegWriteW=1, RdW=0, ResultW=7, then a read of x0 -> 0.
REQ-032 SHALL cover: x1=x2=9, PCPlus4D=0x104, beq x1,x2,-8 -> PCSrcD=1, PCBranchD=0xF8. The same case with bne -> PCSrcD=0.
REQ-033 SHALL cover: jal at PCPlus4D=0x4 with offset -8 -> PCSrcD=1, PCBranchD=0xFFFFFFF8 (wrap).
REQ-034 SHALL cover: FlushE=1 with InstrD=sw -> next edge MemWriteE=0, RegWriteE=0. Undefined opcode 0x7F -> all control 0.
